// File: rtl/handshake_elastic_fifo.sv
// Elastic valid/ready FIFO with registered upstream ready and first-word-fall-through output.
// Optional stats ports (beats_o, stall_o) when HS_FIFO_STATS_EN is defined.
module handshake_elastic_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_pre_i,
  input  logic [DATA_W-1:0]          data_pre_i,
  output logic                       ready_pre_o,
  output logic                       valid_post_o,
  output logic [DATA_W-1:0]          data_post_o,
  input  logic                       ready_post_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       almost_full_o
`ifdef HS_FIFO_STATS_EN
  ,
  output logic [15:0]                beats_o,
  output logic [15:0]                stall_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic              push;
  logic              pop;

  assign push = valid_pre_i & ready_pre_o;
  assign pop  = valid_post_o & ready_post_i;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ready_pre_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      // Ready looks at next occupancy only, so downstream ready never reaches it combinationally.
      ready_pre_o <= (count_next != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_pre_i;
  end

  assign valid_post_o  = (count != '0);
  assign data_post_o   = valid_post_o ? mem[rd_ptr] : '0;
  assign count_o       = count;
  assign almost_full_o = (count >= CNT_W'(AF_LEVEL));

`ifdef HS_FIFO_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_o <= '0;
      stall_o <= '0;
    end else begin
      if (pop && beats_o != 16'hFFFF) beats_o <= beats_o + 16'd1;
      if (valid_post_o && !ready_post_i && stall_o != 16'hFFFF) stall_o <= stall_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: queue-based reference model checked every cycle plus literal checks.
// Build with HS_FIFO_STATS_EN defined to also cover beats_o/stall_o.
module tb_handshake_elastic_fifo;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;
  localparam int CNT_W    = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              valid_pre_i = 1'b0;
  logic [DATA_W-1:0] data_pre_i = '0;
  logic              ready_pre_o;
  logic              valid_post_o;
  logic [DATA_W-1:0] data_post_o;
  logic              ready_post_i = 1'b0;
  logic [CNT_W-1:0]  count_o;
  logic              almost_full_o;
`ifdef HS_FIFO_STATS_EN
  logic [15:0]       beats_o;
  logic [15:0]       stall_o;
`endif

  handshake_elastic_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_pre_i   (valid_pre_i),
    .data_pre_i    (data_pre_i),
    .ready_pre_o   (ready_pre_o),
    .valid_post_o  (valid_post_o),
    .data_post_o   (data_post_o),
    .ready_post_i  (ready_post_i),
    .count_o       (count_o),
    .almost_full_o (almost_full_o)
`ifdef HS_FIFO_STATS_EN
    ,
    .beats_o       (beats_o),
    .stall_o       (stall_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored beats plus the ready the upstream should see.
  logic [DATA_W-1:0] mq[$];
  bit                m_ready = 1'b0;
  int                m_beats = 0;
  int                m_stall = 0;
  bit                m_push, m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ready = 1'b0;
      m_beats = 0;
      m_stall = 0;
    end else begin
      m_push = valid_pre_i && m_ready;
      m_pop  = (mq.size() != 0) && ready_post_i;
      if (mq.size() != 0 && !ready_post_i && m_stall < 65535) m_stall++;
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_beats < 65535) m_beats++;
      end
      if (m_push) mq.push_back(data_pre_i);
      m_ready = (mq.size() != DEPTH);
    end
  end

  bit                chk_en = 1'b0;
  int                n_model;
  int                max_cnt, min_cnt;
  logic [DATA_W-1:0] dut_out[$];

  always @(negedge clk) begin
    if (chk_en) begin
      n_model = mq.size();
      check("valid_post", 32'(valid_post_o), 32'(n_model != 0));
      check("data_post", 32'(data_post_o), (n_model != 0) ? 32'(mq[0]) : 32'd0);
      check("ready_pre", 32'(ready_pre_o), 32'(m_ready));
      check("count", 32'(count_o), 32'(n_model));
      check("almost_full", 32'(almost_full_o), 32'(n_model >= AF_LEVEL));
`ifdef HS_FIFO_STATS_EN
      check("beats", 32'(beats_o), 32'(m_beats));
      check("stall", 32'(stall_o), 32'(m_stall));
`endif
      if (int'(count_o) > max_cnt) max_cnt = int'(count_o);
      if (int'(count_o) < min_cnt) min_cnt = int'(count_o);
      if (valid_post_o && ready_post_i) dut_out.push_back(data_post_o);
    end
  end

  // Upstream producer: holds each beat until the DUT accepts it.
  logic [DATA_W-1:0] src_q[$];
  bit                acc;

  task automatic run_cycles(input int n);
    valid_pre_i = (src_q.size() != 0);
    data_pre_i  = (src_q.size() != 0) ? src_q[0] : '0;
    repeat (n) begin
      @(negedge clk);
      acc = valid_pre_i && ready_pre_o;
      @(posedge clk);
      #1;
      if (acc) void'(src_q.pop_front());
      valid_pre_i = (src_q.size() != 0);
      data_pre_i  = (src_q.size() != 0) ? src_q[0] : '0;
    end
  endtask

  task automatic do_reset();
    src_q.delete();
    valid_pre_i  = 1'b0;
    data_pre_i   = '0;
    ready_post_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_pre_o), 32'd0);
    check("rst_valid", 32'(valid_post_o), 32'd0);
    check("rst_data", 32'(data_post_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_rise", 32'(ready_pre_o), 32'd1);
  endtask

  task automatic fill_test();
    ready_post_i = 1'b0;
    dut_out.delete();
    for (int i = 0; i < 6; i++) src_q.push_back(8'hA0 + 8'(i));
    run_cycles(6);
    check("t3_count", 32'(count_o), 32'd4);
    check("t3_ready", 32'(ready_pre_o), 32'd0);
    check("t3_head", 32'(data_post_o), 32'hA0);
    check("t3_af", 32'(almost_full_o), 32'd1);
    check("t3_held_valid", 32'(valid_pre_i), 32'd1);
    check("t3_held_data", 32'(data_pre_i), 32'hA4);
  endtask

  task automatic drain_test();
    ready_post_i = 1'b1;
    run_cycles(10);
    check("t4_nout", 32'(dut_out.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < dut_out.size()) check("t4_order", 32'(dut_out[i]), 32'hA0 + 32'(i));
    check("t4_empty", 32'(count_o), 32'd0);
  endtask

  initial begin
    #2;
    chk_en = 1'b1;
    do_reset();

    // Pass-through
    ready_post_i = 1'b1;
    dut_out.delete();
    max_cnt = 0; min_cnt = 99;
    src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    run_cycles(6);
    check("t2_nout", 32'(dut_out.size()), 32'd3);
    if (dut_out.size() == 3) begin
      check("t2_b0", 32'(dut_out[0]), 32'h11);
      check("t2_b1", 32'(dut_out[1]), 32'h22);
      check("t2_b2", 32'(dut_out[2]), 32'h33);
    end
    check("t2_maxcnt", 32'(max_cnt), 32'd1);

    fill_test();
    drain_test();

    // Steady push+pop at occupancy 2
    ready_post_i = 1'b0;
    dut_out.delete();
    src_q.push_back(8'hB0); src_q.push_back(8'hB1);
    run_cycles(2);
    check("t5_prefill", 32'(count_o), 32'd2);
    for (int i = 2; i < 12; i++) src_q.push_back(8'hB0 + 8'(i));
    ready_post_i = 1'b1;
    max_cnt = 0; min_cnt = 99;
    run_cycles(10);
    check("t5_maxcnt", 32'(max_cnt), 32'd2);
    check("t5_mincnt", 32'(min_cnt), 32'd2);
    check("t5_nout", 32'(dut_out.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < dut_out.size()) check("t5_order", 32'(dut_out[i]), 32'hB0 + 32'(i));
    run_cycles(4);
    check("t5_drained", 32'(count_o), 32'd0);

`ifdef HS_FIFO_STATS_EN
    do_reset();
    check("t6_beats_rst", 32'(beats_o), 32'd0);
    fill_test();
    check("t6_stall_fill", 32'(stall_o), 32'd5);
    drain_test();
    check("t6_beats", 32'(beats_o), 32'd6);
    check("t6_stall", 32'(stall_o), 32'd5);
`endif

    // Reset while holding data
    ready_post_i = 1'b0;
    src_q.push_back(8'hC0); src_q.push_back(8'hC1);
    run_cycles(3);
    check("mid_count", 32'(count_o), 32'd2);
    src_q.delete();
    valid_pre_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(valid_post_o), 32'd0);
    check("mid_data", 32'(data_post_o), 32'd0);
    check("mid_cnt0", 32'(count_o), 32'd0);
    check("mid_ready", 32'(ready_pre_o), 32'd0);
`ifdef HS_FIFO_STATS_EN
    check("mid_beats", 32'(beats_o), 32'd0);
    check("mid_stall", 32'(stall_o), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_cycles(3);
    check("post_rst_valid", 32'(valid_post_o), 32'd0);

    @(posedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
